// File: rtl/hd63701_ccr_unit.sv
// HD63701 condition-code register stage.
// Latches ALU flags under a per-flag mask, owns the I bit and its
// post-CLI IRQ hold-off counter, evaluates Bcc conditions and gates
// interrupt requests toward the sequencer.
// Optional NMI edge capture is built only when HD63701_CCR_NMI_EN is defined.
module hd63701_ccr_unit #(
  parameter logic [2:0] IRQ_DELAY = 3'd1,
  parameter logic [7:0] RESET_CCR = 8'hD0
) (
  input  logic       CLKx2,
  input  logic       RST,
  input  logic       EN,
  input  logic [5:0] alu_rc,
  input  logic [5:0] ccr_mask,
  input  logic       ccr_ld,
  input  logic [7:0] ccr_din,
  input  logic       set_i,
  input  logic       clr_i,
  input  logic       bcc_req,
  input  logic [3:0] bcc_cond,
  output logic       bcc_taken,
  output logic       bcc_valid,
  input  logic       irq_in,
  output logic       irq_take,
  input  logic       int_ack,
  input  logic       nmi_in,
  output logic       nmi_take,
  output logic [7:0] ccr
);

  logic [7:0] ccr_q, ccr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       irq_take_q, irq_take_d;
  logic       bcc_taken_q, bcc_taken_d;
  logic       bcc_valid_q, bcc_valid_d;
  logic       nmi_pend_q, nmi_pend_d;

  // Branch condition from {N,Z,V,C}; odd opcodes are the inverse of the even ones.
  function automatic logic bccEval(input logic [3:0] cond, input logic [7:0] cc);
    logic n, z, v, c, r;
    n = cc[3];
    z = cc[2];
    v = cc[1];
    c = cc[0];
    case (cond[3:1])
      3'd0:    r = 1'b1;
      3'd1:    r = ~(c | z);
      3'd2:    r = ~c;
      3'd3:    r = ~z;
      3'd4:    r = ~v;
      3'd5:    r = ~n;
      3'd6:    r = ~(n ^ v);
      default: r = ~(z | (n ^ v));
    endcase
    return r ^ cond[0];
  endfunction

  // Next CCR: a whole load beats flag/I updates; set_i beats clr_i.
  always_comb begin
    ccr_d = ccr_q;
    if (EN) begin
      if (ccr_ld) begin
        ccr_d = ccr_din | 8'hC0;
      end else begin
        if (ccr_mask[5]) ccr_d[5] = alu_rc[5];
        if (ccr_mask[3]) ccr_d[3] = alu_rc[3];
        if (ccr_mask[2]) ccr_d[2] = alu_rc[2];
        if (ccr_mask[1]) ccr_d[1] = alu_rc[1];
        if (ccr_mask[0]) ccr_d[0] = alu_rc[0];
        if (set_i)       ccr_d[4] = 1'b1;
        else if (clr_i)  ccr_d[4] = 1'b0;
      end
    end
  end

  // Hold-off counter: reloads only on a real I 1->0 transition, cleared while I is set.
  always_comb begin
    cnt_d = cnt_q;
    if (EN) begin
      if (ccr_d[4])            cnt_d = 3'd0;
      else if (ccr_q[4])       cnt_d = IRQ_DELAY;
      else if (cnt_q != 3'd0)  cnt_d = cnt_q - 3'd1;
    end
  end

  // IRQ decision and branch result, both evaluated only on enabled microsteps.
  always_comb begin
    irq_take_d  = irq_take_q;
    bcc_taken_d = bcc_taken_q;
    bcc_valid_d = EN & bcc_req;
    if (EN) begin
      irq_take_d = irq_in & ~ccr_d[4] & (cnt_d == 3'd0) & ~nmi_pend_d;
      if (bcc_req) bcc_taken_d = bccEval(bcc_cond, ccr_q);
    end
  end

  // Main state register.
  always_ff @(posedge CLKx2 or posedge RST) begin
    if (RST) begin
      ccr_q       <= RESET_CCR | 8'hC0;
      cnt_q       <= 3'd0;
      irq_take_q  <= 1'b0;
      bcc_taken_q <= 1'b0;
      bcc_valid_q <= 1'b0;
    end else begin
      ccr_q       <= ccr_d;
      cnt_q       <= cnt_d;
      irq_take_q  <= irq_take_d;
      bcc_taken_q <= bcc_taken_d;
      bcc_valid_q <= bcc_valid_d;
    end
  end

`ifdef HD63701_CCR_NMI_EN
  logic nmi_prev_q;
  logic unused_ok;
  assign unused_ok = ^{alu_rc[4], ccr_mask[4]};

  // A fresh NMI edge outranks an acknowledge landing in the same cycle.
  always_comb begin
    nmi_pend_d = nmi_pend_q;
    if (nmi_in & ~nmi_prev_q)  nmi_pend_d = 1'b1;
    else if (EN & int_ack)     nmi_pend_d = 1'b0;
  end

  // NMI edge detector runs every clock, regardless of EN.
  always_ff @(posedge CLKx2 or posedge RST) begin
    if (RST) begin
      nmi_prev_q <= 1'b0;
      nmi_pend_q <= 1'b0;
    end else begin
      nmi_prev_q <= nmi_in;
      nmi_pend_q <= nmi_pend_d;
    end
  end
`else
  logic unused_ok;
  assign unused_ok  = ^{alu_rc[4], ccr_mask[4], nmi_in, int_ack};
  assign nmi_pend_q = 1'b0;
  assign nmi_pend_d = 1'b0;
`endif

  assign ccr       = ccr_q;
  assign bcc_taken = bcc_taken_q;
  assign bcc_valid = bcc_valid_q;
  assign irq_take  = irq_take_q & ~nmi_pend_q;
  assign nmi_take  = nmi_pend_q;

endmodule

// File: tb/tb_hd63701_ccr_unit.sv
// Self-checking bench for hd63701_ccr_unit (default parameters).
// Expected outputs are queued when each microstep is driven and popped
// once the clock edge has produced the DUT response.
module tb_hd63701_ccr_unit;

  logic       CLKx2 = 1'b0;
  logic       RST, EN, ccr_ld, set_i, clr_i, bcc_req, irq_in, int_ack, nmi_in;
  logic [5:0] alu_rc, ccr_mask;
  logic [7:0] ccr_din;
  logic [3:0] bcc_cond;
  logic       bcc_taken, bcc_valid, irq_take, nmi_take;
  logic [7:0] ccr;

  typedef struct packed {
    logic       en;
    logic       ld;
    logic [7:0] din;
    logic       seti;
    logic       clri;
    logic [5:0] alu;
    logic [5:0] mask;
    logic       req;
    logic [3:0] cond;
    logic       irq;
    logic       nmi;
    logic       ack;
    logic [11:0] exp;
  } step_t;

  logic [11:0] sbq[$];
  int errors = 0;
  int checks = 0;

  hd63701_ccr_unit dut (
    .CLKx2(CLKx2), .RST(RST), .EN(EN), .alu_rc(alu_rc), .ccr_mask(ccr_mask),
    .ccr_ld(ccr_ld), .ccr_din(ccr_din), .set_i(set_i), .clr_i(clr_i),
    .bcc_req(bcc_req), .bcc_cond(bcc_cond), .bcc_taken(bcc_taken),
    .bcc_valid(bcc_valid), .irq_in(irq_in), .irq_take(irq_take),
    .int_ack(int_ack), .nmi_in(nmi_in), .nmi_take(nmi_take), .ccr(ccr)
  );

  always #5 CLKx2 = ~CLKx2;

  function automatic logic [11:0] obs();
    return {ccr, irq_take, nmi_take, bcc_taken, bcc_valid};
  endfunction

  function automatic step_t st(input logic en, input logic ld, input logic [7:0] din,
                               input logic seti, input logic clri, input logic [5:0] alu,
                               input logic [5:0] mask, input logic req, input logic [3:0] cond,
                               input logic irq, input logic nmi, input logic ack,
                               input logic [7:0] eccr, input logic eirq, input logic enmi,
                               input logic ebt, input logic ebv);
    step_t s;
    s.en = en; s.ld = ld; s.din = din; s.seti = seti; s.clri = clri;
    s.alu = alu; s.mask = mask; s.req = req; s.cond = cond;
    s.irq = irq; s.nmi = nmi; s.ack = ack;
    s.exp = {eccr, eirq, enmi, ebt, ebv};
    return s;
  endfunction

  task automatic applyStimulus(input step_t s);
    EN = s.en; ccr_ld = s.ld; ccr_din = s.din; set_i = s.seti; clr_i = s.clri;
    alu_rc = s.alu; ccr_mask = s.mask; bcc_req = s.req; bcc_cond = s.cond;
    irq_in = s.irq; nmi_in = s.nmi; int_ack = s.ack;
  endtask

  task automatic tick();
    @(posedge CLKx2);
    #1;
  endtask

  task automatic test_reset();
    step_t s[$];
    logic [11:0] got, want;
    applyStimulus(st(0,0,8'h00,0,0,6'h00,6'h00,0,4'h0,0,0,0, 8'h00,0,0,0,0));
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    got = obs();
    checks++;
    if (got !== {8'hD0, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL reset got ccr=%h flags=%b want ccr=d0 flags=0000", got[11:4], got[3:0]);
    end
    s.push_back(st(0,1,8'h00,1,1,6'h3F,6'h3F,1,4'h0,1,0,0, 8'hD0,0,0,0,0));
    s.push_back(st(0,0,8'h00,0,1,6'h3F,6'h3F,1,4'h7,1,0,0, 8'hD0,0,0,0,0));
    foreach (s[i]) begin
      applyStimulus(s[i]); sbq.push_back(s[i].exp); tick();
      got = obs(); want = sbq.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL en_low[%0d] got ccr=%h flags=%b want ccr=%h flags=%b", i, got[11:4], got[3:0], want[11:4], want[3:0]);
      end
    end
  endtask

  task automatic test_flags();
    step_t s[$];
    logic [11:0] got, want;
    s.push_back(st(1,0,8'h00,0,0,6'b101011,6'b000011,0,4'h0,0,0,0, 8'hD3,0,0,0,0));
    s.push_back(st(1,0,8'h00,0,0,6'b111111,6'b101100,0,4'h0,0,0,0, 8'hFF,0,0,0,0));
    s.push_back(st(1,0,8'h00,0,0,6'b000000,6'b111111,0,4'h0,0,0,0, 8'hD0,0,0,0,0));
    foreach (s[i]) begin
      applyStimulus(s[i]); sbq.push_back(s[i].exp); tick();
      got = obs(); want = sbq.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL flags[%0d] got ccr=%h flags=%b want ccr=%h flags=%b", i, got[11:4], got[3:0], want[11:4], want[3:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t s[$];
    logic [11:0] got, want;
    logic [15:0] tbl [2];
    logic [7:0]  pat [2];
    logic        lastBt;
    tbl[0] = 16'hA969; pat[0] = 8'h09;
    tbl[1] = 16'hA699; pat[1] = 8'h06;
    s.push_back(st(1,1,8'h04,0,0,6'h00,6'h00,0,4'h0,0,0,0, 8'hC4,0,0,0,0));
    s.push_back(st(1,0,8'h00,0,0,6'h00,6'h00,1,4'h7,0,0,0, 8'hC4,0,0,1,1));
    s.push_back(st(1,0,8'h00,0,0,6'h00,6'h00,1,4'h6,0,0,0, 8'hC4,0,0,0,1));
    s.push_back(st(1,0,8'h00,0,0,6'h00,6'h00,0,4'h0,0,0,0, 8'hC4,0,0,0,0));
    s.push_back(st(1,0,8'h00,0,0,6'h00,6'b000100,1,4'h7,0,0,0, 8'hC0,0,0,1,1));
    s.push_back(st(0,0,8'h00,0,0,6'h00,6'h00,1,4'h6,0,0,0, 8'hC0,0,0,1,0));
    lastBt = 1'b1;
    for (int p = 0; p < 2; p++) begin
      s.push_back(st(1,1,pat[p],0,0,6'h00,6'h00,0,4'h0,0,0,0, pat[p] | 8'hC0,0,0,lastBt,0));
      for (int c = 0; c < 16; c++) begin
        s.push_back(st(1,0,8'h00,0,0,6'h00,6'h00,1,4'(c),0,0,0, pat[p] | 8'hC0,0,0,tbl[p][c],1));
        lastBt = tbl[p][c];
      end
    end
    foreach (s[i]) begin
      applyStimulus(s[i]); sbq.push_back(s[i].exp); tick();
      got = obs(); want = sbq.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL bcc[%0d] got ccr=%h flags=%b want ccr=%h flags=%b", i, got[11:4], got[3:0], want[11:4], want[3:0]);
      end
    end
  endtask

  task automatic test_irq_delay();
    step_t s[$];
    logic [11:0] got, want;
    s.push_back(st(1,1,8'h10,0,0,6'h00,6'h00,0,4'h0,1,0,0, 8'hD0,0,0,1,0));
    s.push_back(st(1,0,8'h00,0,1,6'h00,6'h00,0,4'h0,1,0,0, 8'hC0,0,0,1,0));
    s.push_back(st(1,0,8'h00,0,0,6'h00,6'h00,0,4'h0,1,0,0, 8'hC0,1,0,1,0));
    s.push_back(st(0,0,8'h00,0,0,6'h00,6'h00,0,4'h0,1,0,0, 8'hC0,1,0,1,0));
    s.push_back(st(1,0,8'h00,0,0,6'h00,6'h00,0,4'h0,0,0,0, 8'hC0,0,0,1,0));
    s.push_back(st(1,0,8'h00,1,0,6'h00,6'h00,0,4'h0,1,0,0, 8'hD0,0,0,1,0));
    s.push_back(st(1,0,8'h00,0,1,6'h00,6'h00,0,4'h0,1,0,0, 8'hC0,0,0,1,0));
    s.push_back(st(1,0,8'h00,1,0,6'h00,6'h00,0,4'h0,1,0,0, 8'hD0,0,0,1,0));
    s.push_back(st(1,0,8'h00,0,0,6'h00,6'h00,0,4'h0,1,0,0, 8'hD0,0,0,1,0));
    s.push_back(st(1,0,8'h00,0,1,6'h00,6'h00,0,4'h0,1,0,0, 8'hC0,0,0,1,0));
    s.push_back(st(0,0,8'h00,0,0,6'h00,6'h00,0,4'h0,1,0,0, 8'hC0,0,0,1,0));
    s.push_back(st(1,0,8'h00,0,0,6'h00,6'h00,0,4'h0,1,0,0, 8'hC0,1,0,1,0));
    s.push_back(st(1,0,8'h00,0,1,6'h00,6'h00,0,4'h0,1,0,0, 8'hC0,1,0,1,0));
    foreach (s[i]) begin
      applyStimulus(s[i]); sbq.push_back(s[i].exp); tick();
      got = obs(); want = sbq.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL irq[%0d] got ccr=%h flags=%b want ccr=%h flags=%b", i, got[11:4], got[3:0], want[11:4], want[3:0]);
      end
    end
  endtask

  task automatic test_load();
    step_t s[$];
    logic [11:0] got, want;
    s.push_back(st(1,0,8'h00,1,0,6'h00,6'h00,0,4'h0,1,0,0, 8'hD0,0,0,1,0));
    s.push_back(st(1,1,8'h00,1,0,6'h3F,6'h3F,0,4'h0,1,0,0, 8'hC0,0,0,1,0));
    s.push_back(st(1,0,8'h00,0,0,6'h00,6'h00,0,4'h0,1,0,0, 8'hC0,1,0,1,0));
    s.push_back(st(1,1,8'hFF,0,1,6'h00,6'h00,0,4'h0,1,0,0, 8'hFF,0,0,1,0));
    s.push_back(st(1,1,8'h00,0,0,6'h00,6'h00,0,4'h0,1,0,0, 8'hC0,0,0,1,0));
    s.push_back(st(1,0,8'h00,0,0,6'h00,6'h00,0,4'h0,1,0,0, 8'hC0,1,0,1,0));
    foreach (s[i]) begin
      applyStimulus(s[i]); sbq.push_back(s[i].exp); tick();
      got = obs(); want = sbq.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL load[%0d] got ccr=%h flags=%b want ccr=%h flags=%b", i, got[11:4], got[3:0], want[11:4], want[3:0]);
      end
    end
  endtask

  task automatic test_nmi();
    step_t s[$];
    logic [11:0] got, want;
`ifdef HD63701_CCR_NMI_EN
    s.push_back(st(0,0,8'h00,0,0,6'h00,6'h00,0,4'h0,1,1,0, 8'hC0,0,1,1,0));
    s.push_back(st(0,0,8'h00,0,0,6'h00,6'h00,0,4'h0,1,0,0, 8'hC0,0,1,1,0));
    s.push_back(st(1,0,8'h00,0,0,6'h00,6'h00,0,4'h0,1,0,0, 8'hC0,0,1,1,0));
    s.push_back(st(1,0,8'h00,0,0,6'h00,6'h00,0,4'h0,1,0,1, 8'hC0,1,0,1,0));
    s.push_back(st(0,0,8'h00,0,0,6'h00,6'h00,0,4'h0,1,1,0, 8'hC0,0,1,1,0));
    s.push_back(st(0,0,8'h00,0,0,6'h00,6'h00,0,4'h0,1,0,0, 8'hC0,0,1,1,0));
    s.push_back(st(1,0,8'h00,0,0,6'h00,6'h00,0,4'h0,1,1,1, 8'hC0,0,1,1,0));
    s.push_back(st(1,0,8'h00,0,0,6'h00,6'h00,0,4'h0,1,1,1, 8'hC0,1,0,1,0));
    s.push_back(st(0,0,8'h00,0,0,6'h00,6'h00,0,4'h0,1,0,0, 8'hC0,1,0,1,0));
    s.push_back(st(0,0,8'h00,0,0,6'h00,6'h00,0,4'h0,1,1,0, 8'hC0,0,1,1,0));
`else
    s.push_back(st(0,0,8'h00,0,0,6'h00,6'h00,0,4'h0,1,1,0, 8'hC0,1,0,1,0));
    s.push_back(st(1,0,8'h00,0,0,6'h00,6'h00,0,4'h0,1,0,1, 8'hC0,1,0,1,0));
    s.push_back(st(1,0,8'h00,0,0,6'h00,6'h00,0,4'h0,1,1,0, 8'hC0,1,0,1,0));
`endif
    foreach (s[i]) begin
      applyStimulus(s[i]); sbq.push_back(s[i].exp); tick();
      got = obs(); want = sbq.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL nmi[%0d] got ccr=%h flags=%b want ccr=%h flags=%b", i, got[11:4], got[3:0], want[11:4], want[3:0]);
      end
    end
    // Asynchronous reset between clock edges with state pending.
    #2;
    RST = 1'b1;
    #1;
    got = obs();
    checks++;
    if (got !== {8'hD0, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL async_reset got ccr=%h flags=%b want ccr=d0 flags=0000", got[11:4], got[3:0]);
    end
    applyStimulus(st(0,0,8'h00,0,0,6'h00,6'h00,0,4'h0,0,0,0, 8'h00,0,0,0,0));
    tick();
    RST = 1'b0;
  endtask

  initial begin
    $display("[TB] hd63701_ccr_unit bench start");
    test_reset();
    test_flags();
    test_back_to_back();
    test_irq_delay();
    test_load();
    test_nmi();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
